// File: rtl/nasti_stream_pkg.sv
// Shared NASTI stream definitions: default field widths and the beat record
// stored by stream buffering blocks.
package nasti_stream_pkg;

  localparam int NASTI_DATA_WIDTH = 64;
  localparam int NASTI_STRB_WIDTH = NASTI_DATA_WIDTH / 8;
  localparam int NASTI_ID_WIDTH   = 1;
  localparam int NASTI_DEST_WIDTH = 1;
  localparam int NASTI_USER_WIDTH = 1;

  typedef struct packed {
    logic [NASTI_DATA_WIDTH-1:0] data;
    logic [NASTI_STRB_WIDTH-1:0] strb;
    logic [NASTI_STRB_WIDTH-1:0] keep;
    logic                        last;
    logic [NASTI_ID_WIDTH-1:0]   id;
    logic [NASTI_DEST_WIDTH-1:0] dest;
    logic [NASTI_USER_WIDTH-1:0] user;
  } beat_t;

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI stream channel bundle; each signal carries one lane per port.
interface nasti_stream_channel #(
  parameter int N_PORT     = 1,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [N_PORT-1:0]                 t_valid;
  logic [N_PORT-1:0]                 t_ready;
  logic [N_PORT-1:0][DATA_WIDTH-1:0] t_data;
  logic [N_PORT-1:0][STRB_WIDTH-1:0] t_strb;
  logic [N_PORT-1:0][STRB_WIDTH-1:0] t_keep;
  logic [N_PORT-1:0]                 t_last;
  logic [N_PORT-1:0][ID_WIDTH-1:0]   t_id;
  logic [N_PORT-1:0][DEST_WIDTH-1:0] t_dest;
  logic [N_PORT-1:0][USER_WIDTH-1:0] t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );

endinterface

// File: rtl/nasti_stream_fifo_ram.sv
// Beat storage for the stream FIFO: one synchronous write port and one
// asynchronous read port so the head entry falls through to the output.
module nasti_stream_fifo_ram
  import nasti_stream_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  beat_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output beat_t                    rdata
);

  beat_t mem [DEPTH];

  // NOTE: storage is deliberately not reset; the occupancy count alone decides
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nasti_stream_fifo.sv
// First-word fall-through FIFO for a NASTI stream, with an optional packet
// mode that withholds output until a complete packet has been buffered.
module nasti_stream_fifo
  import nasti_stream_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter bit PKT_MODE   = 1'b0,
  parameter int DATA_WIDTH = NASTI_DATA_WIDTH,
  parameter int ID_WIDTH   = NASTI_ID_WIDTH,
  parameter int DEST_WIDTH = NASTI_DEST_WIDTH,
  parameter int USER_WIDTH = NASTI_USER_WIDTH
) (
  input  logic                   aclk,
  input  logic                   areset,
  nasti_stream_channel.slave     s,
  nasti_stream_channel.master    m,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] pkt_count
);

  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = AW + 1;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  beat_t         wr_beat;
  beat_t         rd_beat;
  logic          full;
  logic          empty;
  logic          in_ready;
  logic          out_valid;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Input readiness ignores the output side: a full FIFO refuses a beat even
  // when a read frees an entry in the same cycle.
  assign in_ready = !full && !areset;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_valid = 1'b0;
    if (!empty) begin
      // The full-FIFO release lets packets longer than DEPTH drain.
      out_valid = PKT_MODE ? ((pkt_count != '0) || full) : 1'b1;
    end
  end

  assign wr_en   = s.t_valid[0] && in_ready;
  assign rd_en   = out_valid && m.t_ready[0];
  assign wr_last = wr_en && s.t_last[0];
  assign rd_last = rd_en && rd_beat.last;

  assign wr_beat = '{
    data: s.t_data[0],
    strb: s.t_strb[0],
    keep: s.t_keep[0],
    last: s.t_last[0],
    id:   s.t_id[0],
    dest: s.t_dest[0],
    user: s.t_user[0]
  };

  nasti_stream_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_beat),
    .raddr (rd_ptr),
    .rdata (rd_beat)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
    end else begin
      // Power-of-two depth: pointer overflow is the wrap to entry 0.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en != rd_en) count <= wr_en ? count + CW'(1) : count - CW'(1);
      if (wr_last != rd_last) pkt_count <= wr_last ? pkt_count + CW'(1) : pkt_count - CW'(1);
    end
  end

  assign s.t_ready[0] = in_ready;
  assign m.t_valid[0] = out_valid;
  assign m.t_data[0]  = DATA_WIDTH'(rd_beat.data);
  assign m.t_strb[0]  = STRB_WIDTH'(rd_beat.strb);
  assign m.t_keep[0]  = STRB_WIDTH'(rd_beat.keep);
  assign m.t_last[0]  = rd_beat.last;
  assign m.t_id[0]    = ID_WIDTH'(rd_beat.id);
  assign m.t_dest[0]  = DEST_WIDTH'(rd_beat.dest);
  assign m.t_user[0]  = USER_WIDTH'(rd_beat.user);

endmodule

// File: tb/tb_nasti_stream_fifo.sv
// Bench for nasti_stream_fifo: three configurations share one stimulus bus and
// are compared every cycle against a queue-based model of the stream rules.
module tb_nasti_stream_fifo;
  import nasti_stream_pkg::*;

  localparam int N_DUT = 3;
  localparam int DEPTHS [N_DUT] = '{4, 8, 4};
  localparam bit PKTS   [N_DUT] = '{1'b0, 1'b1, 1'b1};

  logic  clk = 1'b0;
  logic  areset;
  logic  in_valid  [N_DUT];
  logic  out_ready [N_DUT];
  beat_t in_beat;

  logic       dut_ready [N_DUT];
  logic       dut_valid [N_DUT];
  beat_t      dut_beat  [N_DUT];
  logic [7:0] dut_count [N_DUT];
  logic [7:0] dut_pkts  [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    nasti_stream_channel s_ch ();
    nasti_stream_channel m_ch ();
    logic [$clog2(DEPTHS[g]):0] cnt;
    logic [$clog2(DEPTHS[g]):0] pcnt;

    assign s_ch.t_valid[0] = in_valid[g];
    assign s_ch.t_data[0]  = in_beat.data;
    assign s_ch.t_strb[0]  = in_beat.strb;
    assign s_ch.t_keep[0]  = in_beat.keep;
    assign s_ch.t_last[0]  = in_beat.last;
    assign s_ch.t_id[0]    = in_beat.id;
    assign s_ch.t_dest[0]  = in_beat.dest;
    assign s_ch.t_user[0]  = in_beat.user;
    assign m_ch.t_ready[0] = out_ready[g];

    assign dut_ready[g] = s_ch.t_ready[0];
    assign dut_valid[g] = m_ch.t_valid[0];
    assign dut_beat[g]  = '{data: m_ch.t_data[0], strb: m_ch.t_strb[0], keep: m_ch.t_keep[0],
                            last: m_ch.t_last[0], id: m_ch.t_id[0], dest: m_ch.t_dest[0],
                            user: m_ch.t_user[0]};
    assign dut_count[g] = 8'(cnt);
    assign dut_pkts[g]  = 8'(pcnt);

    nasti_stream_fifo #(
      .DEPTH    (DEPTHS[g]),
      .PKT_MODE (PKTS[g])
    ) u_dut (
      .aclk      (clk),
      .areset    (areset),
      .s         (s_ch),
      .m         (m_ch),
      .count     (cnt),
      .pkt_count (pcnt)
    );
  end

  // Reference model: each FIFO is just an ordered queue of beats.
  beat_t mq [N_DUT][$];
  bit    fire_w [N_DUT];
  bit    fire_r [N_DUT];
  int    n_total = 0;
  int    n_bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int lasts_of(input int i);
    int n = 0;
    for (int k = 0; k < mq[i].size(); k++) if (mq[i][k].last) n++;
    return n;
  endfunction

  function automatic bit model_ready(input int i);
    return !areset && (mq[i].size() < DEPTHS[i]);
  endfunction

  function automatic bit model_valid(input int i);
    int n = mq[i].size();
    return (n != 0) && (!PKTS[i] || lasts_of(i) != 0 || n == DEPTHS[i]);
  endfunction

  task automatic model_check();
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("u%0d s_ready", i), dut_ready[i], model_ready(i));
      check($sformatf("u%0d m_valid", i), dut_valid[i], model_valid(i));
      check($sformatf("u%0d count", i), dut_count[i], mq[i].size());
      check($sformatf("u%0d pkt_count", i), dut_pkts[i], lasts_of(i));
      if (model_valid(i)) check($sformatf("u%0d head beat", i), dut_beat[i], mq[i][0]);
      fire_w[i] = in_valid[i] && model_ready(i);
      fire_r[i] = model_valid(i) && out_ready[i];
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < N_DUT; i++) begin
      if (areset) mq[i].delete();
      else begin
        if (fire_r[i]) void'(mq[i].pop_front());
        if (fire_w[i]) mq[i].push_back(in_beat);
      end
    end
  endtask

  task automatic finish_cycle();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic idle();
    for (int i = 0; i < N_DUT; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
    end
  endtask

  task automatic mk_beat(input logic [63:0] d, input logic l);
    in_beat.data = d;
    in_beat.strb = d[7:0] ^ 8'h5a;
    in_beat.keep = ~d[15:8];
    in_beat.last = l;
    in_beat.id   = d[0];
    in_beat.dest = d[1];
    in_beat.user = d[2];
  endtask

  typedef struct {
    logic        valid;
    logic [63:0] data;
    logic        rdy;
    logic        exp_ready;
    logic        exp_valid;
    int          exp_count;
    logic [63:0] exp_data;
  } vec_t;

  vec_t v1 [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    bit first_seen;

    // Write A0..A3 into a stalled depth-4 FIFO, then drain it.
    v1[0] = '{1'b1, 64'hA0, 1'b0, 1'b1, 1'b0, 0, 64'h0};
    v1[1] = '{1'b1, 64'hA1, 1'b0, 1'b1, 1'b1, 1, 64'hA0};
    v1[2] = '{1'b1, 64'hA2, 1'b0, 1'b1, 1'b1, 2, 64'hA0};
    v1[3] = '{1'b1, 64'hA3, 1'b0, 1'b1, 1'b1, 3, 64'hA0};
    v1[4] = '{1'b0, 64'hA3, 1'b0, 1'b0, 1'b1, 4, 64'hA0};
    v1[5] = '{1'b0, 64'hA3, 1'b1, 1'b0, 1'b1, 4, 64'hA0};
    v1[6] = '{1'b0, 64'hA3, 1'b1, 1'b1, 1'b1, 3, 64'hA1};
    v1[7] = '{1'b0, 64'hA3, 1'b1, 1'b1, 1'b1, 2, 64'hA2};
    v1[8] = '{1'b0, 64'hA3, 1'b1, 1'b1, 1'b1, 1, 64'hA3};
    v1[9] = '{1'b0, 64'hA3, 1'b1, 1'b1, 1'b0, 0, 64'h0};

    areset = 1'b1;
    idle();
    mk_beat(64'h0, 1'b0);
    tick();
    @(negedge clk);
    check("reset s_ready", dut_ready[0], 1'b0);
    check("reset m_valid", dut_valid[0], 1'b0);
    finish_cycle();
    areset = 1'b0;

    for (int r = 0; r < 10; r++) begin
      in_valid[0]  = v1[r].valid;
      out_ready[0] = v1[r].rdy;
      mk_beat(v1[r].data, 1'b0);
      @(negedge clk);
      check($sformatf("v1[%0d] s_ready", r), dut_ready[0], v1[r].exp_ready);
      check($sformatf("v1[%0d] m_valid", r), dut_valid[0], v1[r].exp_valid);
      check($sformatf("v1[%0d] count", r), dut_count[0], v1[r].exp_count);
      if (v1[r].exp_valid) check($sformatf("v1[%0d] data", r), dut_beat[0].data, v1[r].exp_data);
      finish_cycle();
    end
    idle();

    // Streaming through a depth-4 FIFO: occupancy stays at one, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      mk_beat(64'hB0 + i, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        check("v2 count", dut_count[0], 1);
        check("v2 data", dut_beat[0].data, 64'hB0 + i - 1);
      end
      finish_cycle();
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("v2 tail data", dut_beat[0].data, 64'hB0 + 19);
    finish_cycle();
    @(negedge clk);
    check("v2 drained valid", dut_valid[0], 1'b0);
    finish_cycle();
    idle();

    // Packet mode, depth 8: output held until the last beat is stored.
    for (int b = 0; b < 3; b++) begin
      in_valid[1] = 1'b1;
      mk_beat(64'hC0 + b, b == 2);
      @(negedge clk);
      check("v3 held valid", dut_valid[1], 1'b0);
      finish_cycle();
    end
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("v3 released valid", dut_valid[1], 1'b1);
    check("v3 pkt_count", dut_pkts[1], 1);
    check("v3 count", dut_count[1], 3);
    finish_cycle();
    out_ready[1] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check("v3 drain data", dut_beat[1].data, 64'hC0 + b);
      check("v3 drain last", dut_beat[1].last, b == 2);
      finish_cycle();
    end
    idle();
    tick();

    // Packet mode, depth 4: a 6-beat packet must drain via the full release.
    sent = 0;
    got = 0;
    first_seen = 1'b0;
    out_ready[2] = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid[2] = (sent < 6);
      mk_beat(64'hD0 + sent, sent == 5);
      @(negedge clk);
      if (dut_valid[2] && !first_seen) begin
        first_seen = 1'b1;
        check("v4 first valid count", dut_count[2], 4);
      end
      if (dut_valid[2]) begin
        check("v4 data", dut_beat[2].data, 64'hD0 + got);
        got++;
      end
      if (in_valid[2] && model_ready(2)) sent++;
      finish_cycle();
    end
    check("v4 beats drained", got, 6);
    idle();
    @(negedge clk);
    check("v4 final count", dut_count[2], 0);
    finish_cycle();

    // A last beat written while a last beat is read leaves pkt_count at 1.
    in_valid[0] = 1'b1;
    mk_beat(64'hE0, 1'b1);
    tick();
    mk_beat(64'hE1, 1'b1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("v5 pkt before", dut_pkts[0], 1);
    finish_cycle();
    idle();
    @(negedge clk);
    check("v5 pkt after", dut_pkts[0], 1);
    check("v5 count", dut_count[0], 1);
    check("v5 data", dut_beat[0].data, 64'hE1);
    finish_cycle();
    out_ready[0] = 1'b1;
    tick();
    idle();

    // Reset with three beats stored, plus a partial packet in the depth-8 FIFO.
    for (int b = 0; b < 3; b++) begin
      in_valid[0] = 1'b1;
      in_valid[1] = (b < 2);
      mk_beat(64'hF0 + b, 1'b0);
      tick();
    end
    idle();
    @(negedge clk);
    check("v6 count before reset", dut_count[0], 3);
    finish_cycle();
    areset = 1'b1;
    @(negedge clk);
    check("v6 s_ready in reset", dut_ready[0], 1'b0);
    finish_cycle();
    areset = 1'b0;
    @(negedge clk);
    check("v6 count", dut_count[0], 0);
    check("v6 pkt_count", dut_pkts[0], 0);
    check("v6 m_valid", dut_valid[0], 1'b0);
    check("v6 s_ready", dut_ready[0], 1'b1);
    check("v6 partial dropped", dut_count[1], 0);
    finish_cycle();
    in_valid[1] = 1'b1;
    mk_beat(64'h5F, 1'b1);
    tick();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("v6 new pkt count", dut_pkts[1], 1);
    check("v6 new pkt data", dut_beat[1].data, 64'h5F);
    finish_cycle();
    out_ready[1] = 1'b1;
    tick();
    idle();

    // Randomized traffic against the model, with occasional resets.
    for (int cyc = 0; cyc < 600; cyc++) begin
      int rp = ((cyc / 150) % 2 == 1) ? 1 : 3;
      for (int i = 0; i < N_DUT; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 3) < rp);
      end
      in_beat.data = {$urandom, $urandom};
      in_beat.strb = NASTI_STRB_WIDTH'($urandom);
      in_beat.keep = NASTI_STRB_WIDTH'($urandom);
      in_beat.last = ($urandom_range(0, 4) == 0);
      in_beat.id   = NASTI_ID_WIDTH'($urandom);
      in_beat.dest = NASTI_DEST_WIDTH'($urandom);
      in_beat.user = NASTI_USER_WIDTH'($urandom);
      areset = ($urandom_range(0, 99) == 0);
      tick();
    end
    areset = 1'b0;
    idle();
    for (int i = 0; i < N_DUT; i++) out_ready[i] = 1'b1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
